// File: rtl/lpf_power_trigger.sv
// lpf_power_trigger: squares 8 filtered samples per clock, forms a sliding-window
// power over WINDOW clocks, and runs an arm/holdoff/re-arm threshold trigger
// that timestamps and counts each trigger.
// Optional feature: define LPF_POWER_TRIGGER_PEAK_EN to add peak_o, the maximum
// window power seen while in HOLDOFF.
module lpf_power_trigger #(
  parameter int DATBITS = 13,
  parameter int WINDOW  = 4,
  parameter int HOBITS  = 16,
  parameter int TSBITS  = 32,
  localparam int POWBITS = 2*DATBITS + 3 + $clog2(WINDOW)
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [8*DATBITS-1:0]   dat_i,
  input  logic [POWBITS-1:0]     thresh_i,
  input  logic [HOBITS-1:0]      holdoff_i,
  input  logic                   arm_i,
  output logic [POWBITS-1:0]     power_o,
  output logic                   trig_o,
  output logic [TSBITS-1:0]      trig_time_o,
  output logic [1:0]             state_o,
  output logic [15:0]            trig_count_o
`ifdef LPF_POWER_TRIGGER_PEAK_EN
  ,
  output logic [POWBITS-1:0]     peak_o
`endif
);

  localparam int SQB  = 2*DATBITS;
  localparam int SUMB = SQB + 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    HOLDOFF = 2'd2,
    REARM   = 2'd3
  } state_e;

  logic [8*DATBITS-1:0] dat_q;
  logic [SQB-1:0]       sq_d   [8];
  logic [SQB-1:0]       sq_q   [8];
  logic [SQB:0]         s2_q   [4];
  logic [SQB+1:0]       s3_q   [2];
  logic [SUMB-1:0]      sum_q;
  logic [SUMB-1:0]      hist_q [WINDOW];
  logic [POWBITS-1:0]   acc_q;
  logic                 above_q;

  state_e               state_q;
  logic                 trig_q;
  logic [TSBITS-1:0]    ts_q;
  logic [TSBITS-1:0]    trig_time_q;
  logic [15:0]          trig_count_q;
  logic [HOBITS-1:0]    ho_cnt_q;
`ifdef LPF_POWER_TRIGGER_PEAK_EN
  logic [POWBITS-1:0]   peak_q;
`endif

  // The true square of a DATBITS signed value always fits in 2*DATBITS unsigned bits.
  function automatic logic [SQB-1:0] square(input logic signed [DATBITS-1:0] x);
    logic signed [SQB-1:0] xe;
    xe = SQB'(x);
    return xe * xe;
  endfunction

  // Square each registered sample.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    for (int i = 0; i < 8; i++) sq_d[i] = '0;
    for (int i = 0; i < 8; i++) sq_d[i] = square(dat_q[i*DATBITS +: DATBITS]);
  end

  // Input capture, squares, adder tree, window history, accumulator and comparator.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      dat_q   <= '0;
      sum_q   <= '0;
      acc_q   <= '0;
      above_q <= 1'b0;
      for (int i = 0; i < 8; i++) sq_q[i] <= '0;
      for (int i = 0; i < 4; i++) s2_q[i] <= '0;
      for (int i = 0; i < 2; i++) s3_q[i] <= '0;
      // NOTE: the history is reset like any register; a stale entry would be
      // subtracted from a cleared accumulator and corrupt the running sum.
      for (int i = 0; i < WINDOW; i++) hist_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage reads the previous-cycle values.
      dat_q <= dat_i;
      for (int i = 0; i < 8; i++) sq_q[i] <= sq_d[i];
      for (int i = 0; i < 4; i++) s2_q[i] <= {1'b0, sq_q[2*i]} + {1'b0, sq_q[2*i+1]};
      for (int i = 0; i < 2; i++) s3_q[i] <= {1'b0, s2_q[2*i]} + {1'b0, s2_q[2*i+1]};
      sum_q <= {1'b0, s3_q[0]} + {1'b0, s3_q[1]};
      hist_q[0] <= sum_q;
      for (int i = 1; i < WINDOW; i++) hist_q[i] <= hist_q[i-1];
      acc_q   <= acc_q + POWBITS'(sum_q) - POWBITS'(hist_q[WINDOW-1]);
      above_q <= (acc_q > thresh_i);
    end
  end

  // Free-running timestamp.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) ts_q <= '0;
    else         ts_q <= ts_q + TSBITS'(1);
  end

  // Trigger FSM with registered pulse, timestamp, count and holdoff counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      trig_q       <= 1'b0;
      trig_time_q  <= '0;
      trig_count_q <= '0;
      ho_cnt_q     <= '0;
`ifdef LPF_POWER_TRIGGER_PEAK_EN
      peak_q       <= '0;
`endif
    end else begin
      trig_q <= 1'b0;
      case (state_q)
        IDLE: if (arm_i) state_q <= ARMED;
        ARMED: begin
          // Disarm takes priority over a simultaneous threshold crossing.
          if (!arm_i) begin
            state_q <= IDLE;
          end else if (above_q) begin
            state_q      <= HOLDOFF;
            trig_q       <= 1'b1;
            trig_time_q  <= ts_q;
            trig_count_q <= trig_count_q + 16'd1;
            ho_cnt_q     <= holdoff_i;
`ifdef LPF_POWER_TRIGGER_PEAK_EN
            peak_q       <= acc_q;
`endif
          end
        end
        HOLDOFF: begin
          if (ho_cnt_q == '0) state_q <= REARM;
          else                ho_cnt_q <= ho_cnt_q - HOBITS'(1);
`ifdef LPF_POWER_TRIGGER_PEAK_EN
          if (acc_q > peak_q) peak_q <= acc_q;
`endif
        end
        REARM: begin
          // Only re-arm once the power has dropped to or below threshold.
          if (!arm_i)        state_q <= IDLE;
          else if (!above_q) state_q <= ARMED;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign power_o      = acc_q;
  assign trig_o       = trig_q;
  assign trig_time_o  = trig_time_q;
  assign state_o      = state_q;
  assign trig_count_o = trig_count_q;
`ifdef LPF_POWER_TRIGGER_PEAK_EN
  assign peak_o       = peak_q;
`endif

endmodule

// File: tb/tb_lpf_power_trigger.sv
// Testbench for lpf_power_trigger: table-driven step/trigger vectors on a
// WINDOW=4 instance plus hand sequences for re-arm, disarm, full scale
// (WINDOW=16 instance) and asynchronous reset during holdoff.
module tb_lpf_power_trigger;

  localparam int DB   = 13;
  localparam int PB4  = 31;
  localparam int PB16 = 33;

  logic            clk = 1'b0;
  logic            rstn;
  logic [8*DB-1:0] dat4, dat16;
  logic [PB4-1:0]  thr4, pow4;
  logic [PB16-1:0] thr16, pow16;
  logic [15:0]     ho4, ho16, cnt4, cnt16;
  logic            arm4, arm16, trig4, trig16;
  logic [31:0]     tt4, tt16;
  logic [1:0]      st4, st16;
`ifdef LPF_POWER_TRIGGER_PEAK_EN
  logic [PB4-1:0]  peak4;
  logic [PB16-1:0] peak16;
`endif

  lpf_power_trigger #(.DATBITS(DB), .WINDOW(4)) dut4 (
    .clk_i(clk), .rstn_i(rstn), .dat_i(dat4), .thresh_i(thr4), .holdoff_i(ho4),
    .arm_i(arm4), .power_o(pow4), .trig_o(trig4), .trig_time_o(tt4),
    .state_o(st4), .trig_count_o(cnt4)
`ifdef LPF_POWER_TRIGGER_PEAK_EN
    , .peak_o(peak4)
`endif
  );

  lpf_power_trigger #(.DATBITS(DB), .WINDOW(16)) dut16 (
    .clk_i(clk), .rstn_i(rstn), .dat_i(dat16), .thresh_i(thr16), .holdoff_i(ho16),
    .arm_i(arm16), .power_o(pow16), .trig_o(trig16), .trig_time_o(tt16),
    .state_o(st16), .trig_count_o(cnt16)
`ifdef LPF_POWER_TRIGGER_PEAK_EN
    , .peak_o(peak16)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [DB-1:0]  dat;
    logic           arm;
    logic [PB4-1:0] power;
    logic [1:0]     state;
    logic           trig;
    logic [15:0]    count;
  } vec_t;

  vec_t tbl[21];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [8*DB-1:0] fill(input logic [DB-1:0] v);
    return {8{v}};
  endfunction

  initial begin
    int k0;
    int bad;
    logic seen;

    // Step of 100 with thresh 100000, holdoff 10: entry i is applied before edge i
    // and checked after it. Window of 4 sums of 80000 ramps 80k/160k/240k/320k.
    tbl[0]  = '{13'd100, 1'b1, 31'd0,      2'd1, 1'b0, 16'd0};
    tbl[1]  = '{13'd100, 1'b1, 31'd0,      2'd1, 1'b0, 16'd0};
    tbl[2]  = '{13'd100, 1'b1, 31'd0,      2'd1, 1'b0, 16'd0};
    tbl[3]  = '{13'd100, 1'b1, 31'd0,      2'd1, 1'b0, 16'd0};
    tbl[4]  = '{13'd100, 1'b1, 31'd0,      2'd1, 1'b0, 16'd0};
    tbl[5]  = '{13'd100, 1'b1, 31'd80000,  2'd1, 1'b0, 16'd0};
    tbl[6]  = '{13'd100, 1'b1, 31'd160000, 2'd1, 1'b0, 16'd0};
    tbl[7]  = '{13'd100, 1'b1, 31'd240000, 2'd1, 1'b0, 16'd0};
    tbl[8]  = '{13'd100, 1'b1, 31'd320000, 2'd2, 1'b1, 16'd1};
    tbl[9]  = '{13'd100, 1'b1, 31'd320000, 2'd2, 1'b0, 16'd1};
    tbl[10] = '{13'd100, 1'b1, 31'd320000, 2'd2, 1'b0, 16'd1};
    tbl[11] = '{13'd100, 1'b1, 31'd320000, 2'd2, 1'b0, 16'd1};
    tbl[12] = '{13'd100, 1'b1, 31'd320000, 2'd2, 1'b0, 16'd1};
    tbl[13] = '{13'd100, 1'b1, 31'd320000, 2'd2, 1'b0, 16'd1};
    tbl[14] = '{13'd100, 1'b1, 31'd320000, 2'd2, 1'b0, 16'd1};
    tbl[15] = '{13'd100, 1'b1, 31'd320000, 2'd2, 1'b0, 16'd1};
    tbl[16] = '{13'd100, 1'b1, 31'd320000, 2'd2, 1'b0, 16'd1};
    tbl[17] = '{13'd100, 1'b1, 31'd320000, 2'd2, 1'b0, 16'd1};
    tbl[18] = '{13'd100, 1'b1, 31'd320000, 2'd2, 1'b0, 16'd1};
    tbl[19] = '{13'd100, 1'b1, 31'd320000, 2'd3, 1'b0, 16'd1};
    tbl[20] = '{13'd100, 1'b1, 31'd320000, 2'd3, 1'b0, 16'd1};

    rstn  = 1'b0;
    dat4  = '0;  dat16 = '0;
    thr4  = 31'd100000;  thr16 = 33'd536870911;
    ho4   = 16'd10;      ho16  = 16'd0;
    arm4  = 1'b0;        arm16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset power", pow4, 0);
    check("reset state", st4, 0);
    check("reset trig", trig4, 0);
    check("reset count", cnt4, 0);
    check("reset trig_time", tt4, 0);
    rstn = 1'b1;
    cyc  = 0;

    // Step response and first trigger.
    for (int i = 0; i < 21; i++) begin
      dat4 = fill(tbl[i].dat);
      arm4 = tbl[i].arm;
      tick();
      check($sformatf("step e%0d power", i), pow4, tbl[i].power);
      check($sformatf("step e%0d state", i), st4, tbl[i].state);
      check($sformatf("step e%0d trig", i), trig4, tbl[i].trig);
      check($sformatf("step e%0d count", i), cnt4, tbl[i].count);
    end
    // Trigger decided on edge 8, where the timestamp counter held 8.
    check("first trig_time", tt4, 8);

    // Continuously above threshold: must stay in REARM without retriggering.
    bad  = 0;
    seen = 1'b0;
    repeat (200) begin
      tick();
      if (st4 != 2'd3 || cnt4 != 16'd1) bad++;
      seen |= trig4;
    end
    check("no retrigger state/count", bad, 0);
    check("no retrigger pulse", seen, 0);

    // Drop input: power 240k,160k,80k,0 on edges d+5..d+8; ARMED after d+9.
    dat4 = fill(13'd0);
    for (int k = 0; k <= 8; k++) begin
      tick();
      if (k == 7) check("decay power d+7", pow4, 80000);
    end
    check("still rearm d+8", st4, 3);
    tick();
    check("armed d+9", st4, 1);
    check("power at rearm", pow4, 0);

    // Reapply step: trigger 8 edges later, count becomes 2.
    dat4 = fill(13'd100);
    for (int k = 0; k <= 8; k++) begin
      tick();
      check($sformatf("retrig r+%0d trig", k), trig4, (k == 8));
    end
    check("retrig count", cnt4, 2);
    check("retrig state", st4, 2);
    check("retrig trig_time", tt4, cyc - 1);

    // Disarm during holdoff: holdoff completes, then REARM drops to IDLE.
    arm4 = 1'b0;
    repeat (10) tick();
    check("disarmed holdoff r+18", st4, 2);
    tick();
    check("disarmed rearm r+19", st4, 3);
    tick();
    check("disarmed idle r+20", st4, 0);

    // Disarm race: arm falls on the very edge that first sees above_q.
    dat4 = fill(13'd0);
    repeat (10) tick();
    check("race pre power", pow4, 0);
    arm4 = 1'b1;
    dat4 = fill(13'd100);
    seen = 1'b0;
    repeat (8) begin
      tick();
      seen |= trig4;
    end
    check("race armed q+7", st4, 1);
    arm4 = 1'b0;
    tick();
    seen |= trig4;
    check("race idle", st4, 0);
    check("race no trig", seen, 0);
    check("race count", cnt4, 2);

    // Async reset mid-holdoff.
    ho4  = 16'd50;
    arm4 = 1'b1;
    tick();
    check("pre-reset armed", st4, 1);
    tick();
    check("pre-reset trig", trig4, 1);
    check("pre-reset count", cnt4, 3);
    repeat (3) tick();
    check("pre-reset holdoff", st4, 2);
`ifdef LPF_POWER_TRIGGER_PEAK_EN
    check("peak during holdoff", peak4, 320000);
`endif
    dat4 = fill(13'd0);
    #3;
    rstn = 1'b0;
    #1;
    check("async power", pow4, 0);
    check("async state", st4, 0);
    check("async count", cnt4, 0);
    check("async trig_time", tt4, 0);
`ifdef LPF_POWER_TRIGGER_PEAK_EN
    check("async peak", peak4, 0);
`endif
    #2;
    rstn = 1'b1;
    cyc  = 0;
    bad  = 0;
    seen = 1'b0;
    repeat (30) begin
      tick();
      if (pow4 != '0) bad++;
      seen |= trig4;
    end
    check("post-reset power zero", bad, 0);
    check("post-reset no trig", seen, 0);
    check("post-reset armed", st4, 1);
    check("post-reset count", cnt4, 0);
    // Timestamp restarted at 0: trigger decided on edge k0+8 records k0+8.
    k0 = cyc;
    dat4 = fill(13'd100);
    repeat (9) tick();
    check("post-reset trig", trig4, 1);
    check("post-reset trig_time", tt4, k0 + 8);

    // Full scale, WINDOW=16: 16 * 8 * 2048^2 = 536870912.
    dat16 = fill(13'h1800);
    arm16 = 1'b1;
    repeat (21) tick();
    check("fs power f+20", pow16, 64'd536870912);
    check("fs state f+20", st16, 1);
    tick();
    check("fs trig f+21", trig16, 0);
    tick();
    check("fs trig f+22", trig16, 1);
    check("fs count", cnt16, 1);
    repeat (5) tick();
    check("fs rearm held", st16, 3);
    thr16 = 33'd536870912;
    seen  = 1'b0;
    repeat (30) begin
      tick();
      seen |= trig16;
    end
    check("fs equal-thresh no trig", seen, 0);
    check("fs equal-thresh armed", st16, 1);
    check("fs count held", cnt16, 1);
    check("fs power no wrap", pow16, 64'd536870912);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
